// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Shared definitions for the ALU sequencer: request op codes,
//             ALU one-hot op constants, FSM state encoding, byte/flag layout.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

  localparam int ALU_BYTE_W    = 8;
  localparam int ALU_CARRY_BIT = 0;
  localparam int ALU_OP_W      = 7;

  // Request op codes as seen on req_op; 5..7 are illegal.
  typedef enum logic [2:0] {
    REQ_ADD = 3'd0,
    REQ_SUB = 3'd1,
    REQ_AND = 3'd2,
    REQ_OR  = 3'd3,
    REQ_NOT = 3'd4
  } req_op_e;

  // One-hot op select driven to the ALU.
  localparam logic [ALU_OP_W-1:0] ALU_OP_NONE = 7'b0000000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 7'b0000001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 7'b0000010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 7'b0000100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 7'b0001000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOT  = 7'b0010000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq_op_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_op_decode
//  Purpose  : Combinational decode of a request op code into the ALU one-hot
//             op, whether carry/borrow is chained, and an illegal-op flag.
//  Ports    : op         in  3  request op code
//             alu_op     out 7  ALU one-hot op (0 for illegal)
//             uses_carry out 1  op chains carry/borrow between bytes
//             illegal    out 1  op code is not supported
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq_op_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0]          op,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                uses_carry,
  output logic                illegal
);

  always_comb begin
    alu_op     = ALU_OP_NONE;
    uses_carry = 1'b0;
    illegal    = 1'b0;
    case (op)
      REQ_ADD: begin alu_op = ALU_OP_ADD; uses_carry = 1'b1; end
      REQ_SUB: begin alu_op = ALU_OP_SUB; uses_carry = 1'b1; end
      REQ_AND: alu_op = ALU_OP_AND;
      REQ_OR:  alu_op = ALU_OP_OR;
      REQ_NOT: alu_op = ALU_OP_NOT;
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Drives an 8-bit registered ALU one byte at a time (LSB first)
//             to execute multi-byte ADD/SUB/AND/OR/NOT requests. Each byte
//             is a write cycle (alu_wo) followed by a read cycle (alu_oe);
//             carry/borrow is chained through alu_fi/alu_fo bit 0.
//  Config   : ALU_SEQ_ZERO_FLAG_EN - when defined, adds rsp_zero output
//             (result == 0, registered with rsp_data, 0 for illegal ops).
//  Ports    : clk, rst                     clock, sync active-high reset
//             req_valid/ready/op/a/b/cin   request port
//             rsp_valid/ready/data/carry/err (+rsp_zero) response port
//             alu_a/b/fi/op/wo/oe          ALU drive
//             alu_o/fo                     ALU result and flags
//  Revision : 1.0  initial release
// ============================================================================
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 2
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_op,
  input  logic [8*NBYTES-1:0]     req_a,
  input  logic [8*NBYTES-1:0]     req_b,
  input  logic                    req_cin,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*NBYTES-1:0]     rsp_data,
  output logic                    rsp_carry,
  output logic                    rsp_err,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic                    rsp_zero,
`endif
  output logic [ALU_BYTE_W-1:0]   alu_a,
  output logic [ALU_BYTE_W-1:0]   alu_b,
  output logic [ALU_BYTE_W-1:0]   alu_fi,
  output logic [ALU_OP_W-1:0]     alu_op,
  output logic                    alu_wo,
  output logic                    alu_oe,
  input  logic [ALU_BYTE_W-1:0]   alu_o,
  input  logic [ALU_BYTE_W-1:0]   alu_fo
);

  localparam int DW    = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e                state_q, state_n;
  logic [ALU_OP_W-1:0]   op_q;
  logic                  uses_carry_q;
  logic [DW-1:0]         a_q, b_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  carry_q;
  logic [DW-1:0]         data_q, data_n;
  logic                  err_q;

  logic [ALU_OP_W-1:0]   dec_op;
  logic                  dec_uses_carry;
  logic                  dec_illegal;
  logic                  last_byte;
  logic                  unused_fo;

  // Only the carry bit of the ALU flag bus is consumed.
  assign unused_fo = ^alu_fo[ALU_BYTE_W-1:1];

  alu_seq_op_decode u_decode (
    .op         (req_op),
    .alu_op     (dec_op),
    .uses_carry (dec_uses_carry),
    .illegal    (dec_illegal)
  );

  assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

  // Result with the current ALU byte merged in at the active index.
  always_comb begin
    data_n = data_q;
    data_n[idx_q*8 +: 8] = alu_o;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_n = dec_illegal ? ST_DONE : ST_ISSUE;
      ST_ISSUE: state_n = ST_READ;
      ST_READ:  state_n = last_byte ? ST_DONE : ST_ISSUE;
      ST_DONE:  if (rsp_ready) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= ALU_OP_NONE;
      uses_carry_q <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_n;
      case (state_q)
        ST_IDLE: if (req_valid) begin
          op_q         <= dec_op;
          uses_carry_q <= dec_uses_carry;
          a_q          <= req_a;
          b_q          <= req_b;
          idx_q        <= '0;
          // Logic ops never see a carry, and neither do illegal ones.
          carry_q      <= req_cin & dec_uses_carry;
          data_q       <= '0;
          err_q        <= dec_illegal;
        end
        ST_READ: begin
          data_q <= data_n;
          if (uses_carry_q) carry_q <= alu_fo[ALU_CARRY_BIT];
          if (!last_byte) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (state_q == ST_IDLE && req_valid) begin
      zero_q <= 1'b0;
    end else if (state_q == ST_READ && last_byte) begin
      zero_q <= (data_n == '0);
    end
  end
  assign rsp_zero = zero_q;
`endif

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_fi    = '0;
    alu_op    = ALU_OP_NONE;
    alu_wo    = 1'b0;
    alu_oe    = 1'b0;
    case (state_q)
      ST_IDLE:  req_ready = 1'b1;
      ST_ISSUE: begin
        alu_a  = a_q[idx_q*8 +: 8];
        alu_b  = b_q[idx_q*8 +: 8];
        alu_fi = {{(ALU_BYTE_W-1){1'b0}}, carry_q};
        alu_op = op_q;
        alu_wo = 1'b1;
      end
      ST_READ:  alu_oe = 1'b1;
      ST_DONE:  rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  assign rsp_data  = data_q;
  assign rsp_carry = carry_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sequencer
//  Purpose  : Self-checking bench for alu_sequencer (NBYTES=2) with a
//             behavioural registered 8-bit ALU.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_cin;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, rsp_carry, rsp_err;
  logic [15:0] rsp_data;
  logic [7:0]  alu_a, alu_b, alu_fi, alu_o, alu_fo;
  logic [6:0]  alu_op;
  logic        alu_wo, alu_oe;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic        rsp_zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.NBYTES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .rsp_zero(rsp_zero),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_fi(alu_fi), .alu_op(alu_op),
    .alu_wo(alu_wo), .alu_oe(alu_oe), .alu_o(alu_o), .alu_fo(alu_fo)
  );

  // Behavioural registered ALU.
  logic [7:0] alu_res = 8'h00;
  logic       alu_flag = 1'b0;
  always @(posedge clk) begin
    if (alu_wo) begin
      case (alu_op)
        7'b0000001: {alu_flag, alu_res} <= {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_fi[0]};
        7'b0000010: {alu_flag, alu_res} <= {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_fi[0]};
        7'b0000100: begin alu_res <= alu_a & alu_b; alu_flag <= 1'b0; end
        7'b0001000: begin alu_res <= alu_a | alu_b; alu_flag <= 1'b0; end
        7'b0010000: begin alu_res <= ~alu_a;        alu_flag <= 1'b0; end
        default:    begin alu_res <= 8'hEE;          alu_flag <= 1'b1; end
      endcase
    end
  end
  assign alu_o  = alu_oe ? alu_res : 8'h00;
  assign alu_fo = {7'b0, alu_flag};

  // Bus activity monitor.
  int         wo_cnt, oe_cnt, both_cnt, fi_nz, valid_cnt;
  logic [7:0] fi_byte [2];
  always @(negedge clk) begin
    if (alu_wo && alu_oe) both_cnt++;
    if (alu_wo) begin
      if (wo_cnt < 2) fi_byte[wo_cnt] = alu_fi;
      wo_cnt++;
    end
    if (alu_oe) oe_cnt++;
    if (alu_fi != 8'h00) fi_nz++;
    if (rsp_valid) valid_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_data;
    logic        exp_carry;
    logic        exp_err;
    logic [7:0]  exp_fi1;   // carry chained into byte 1 (arith only)
  } vec_t;

  vec_t vecs [11];

  task automatic clear_mon();
    wo_cnt = 0; oe_cnt = 0; both_cnt = 0; fi_nz = 0; valid_cnt = 0;
    fi_byte[0] = 8'hAA; fi_byte[1] = 8'hAA;
  endtask

  task automatic run_req(input vec_t v, input int hold);
    int   cyc;
    logic arith;
    logic [15:0] d0;
    logic        unstable;
    arith = (v.op == 3'd0 || v.op == 3'd1);
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 1);
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b; req_cin = v.cin;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    clear_mon();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < 50);
    chk("latency", cyc, v.exp_err ? 1 : 5);
    chk("rsp_data", {16'b0, rsp_data}, {16'b0, v.exp_data});
    chk("rsp_carry", {31'b0, rsp_carry}, {31'b0, v.exp_carry});
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, (v.exp_data == 16'h0) && !v.exp_err});
`endif
    chk("wo_count", wo_cnt, v.exp_err ? 0 : 2);
    chk("oe_count", oe_cnt, v.exp_err ? 0 : 2);
    chk("wo_oe_overlap", both_cnt, 0);
    if (arith) begin
      chk("fi_byte0", {24'b0, fi_byte[0]}, {31'b0, v.cin});
      chk("fi_byte1", {24'b0, fi_byte[1]}, {24'b0, v.exp_fi1});
    end else begin
      chk("fi_zero", fi_nz, 0);
    end
    if (hold > 0) begin
      d0 = rsp_data;
      unstable = 1'b0;
      wo_cnt = 0; oe_cnt = 0;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!rsp_valid || req_ready || rsp_data !== d0 || rsp_carry !== v.exp_carry ||
            alu_op != 7'b0 || alu_a != 8'h0 || alu_b != 8'h0 || alu_fi != 8'h0)
          unstable = 1'b1;
      end
      chk("hold_stable", {31'b0, unstable}, 0);
      chk("hold_no_alu", wo_cnt + oe_cnt, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("back_to_idle", {30'b0, rsp_valid, req_ready}, 32'h1);
  endtask

  initial begin
    vec_t v;
    //           op    a        b        cin   data     c     err   fi1
    vecs[0]  = '{3'd0, 16'h12FF, 16'h0001, 1'b0, 16'h1300, 1'b0, 1'b0, 8'h01};
    vecs[1]  = '{3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h01};
    vecs[2]  = '{3'd1, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 8'h01};
    vecs[3]  = '{3'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 8'h01};
    vecs[4]  = '{3'd2, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{3'd3, 16'hF0F0, 16'h3C3C, 1'b1, 16'hFCFC, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{3'd4, 16'h00FF, 16'h1234, 1'b1, 16'hFF00, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{3'd6, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b1, 8'h00};
    vecs[8]  = '{3'd0, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 8'h01};
    vecs[9]  = '{3'd1, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{3'd0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 8'h00};

    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 16'h0; req_b = 16'h0;
    req_cin = 1'b0; rsp_ready = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'b0, req_ready}, 1);
    chk("reset_rsp", {13'b0, rsp_valid, rsp_carry, rsp_err, rsp_data}, 0);
    chk("reset_alu", {7'b0, alu_op, alu_a, alu_b, alu_wo, alu_oe}, 0);
    chk("reset_fi", {24'b0, alu_fi}, 0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("reset_zero", {31'b0, rsp_zero}, 0);
`endif

    for (int i = 0; i < 11; i++) run_req(vecs[i], 0);

    // Response back-pressure held for 10 cycles.
    run_req(vecs[0], 10);

    // Reset in the READ cycle of byte 0 aborts the transaction.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_a = 16'h0FFF; req_b = 16'h0001; req_cin = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);           // ISSUE byte 0
    @(negedge clk);           // READ byte 0
    chk("in_read_state", {31'b0, alu_oe}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    valid_cnt = 0;
    @(negedge clk);
    chk("abort_ready", {31'b0, req_ready}, 1);
    chk("abort_rsp", {13'b0, rsp_valid, rsp_carry, rsp_err, rsp_data}, 0);
    chk("abort_alu", {7'b0, alu_op, alu_a, alu_b, alu_wo, alu_oe}, 0);
    repeat (8) @(negedge clk);
    chk("abort_no_rsp", valid_cnt, 0);
    v = '{3'd0, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 8'h01};
    run_req(v, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
